// File: rtl/cv32e40p_ft_replica_mgr.sv
// N-modular redundancy manager: votes three active replicas, retires replicas whose
// leaky error counters reach THRESH, and swaps in clock-gated spares under a stall.
module cv32e40p_ft_replica_mgr #(
    parameter int WIDTH    = 32,
    parameter int NREP     = 4,
    parameter int CNT_W    = 4,
    parameter int THRESH   = 8,
    parameter int DECAY    = 256,
    parameter int SWAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [NREP*WIDTH-1:0] res_i,
    input  logic                  clear_i,
    output logic [WIDTH-1:0]      result_o,
    output logic                  ready_o,
    output logic                  err_detected_o,
    output logic                  err_corrected_o,
    output logic [NREP-1:0]       active_mask_o,
    output logic [NREP-1:0]       clock_en_o,
    output logic [NREP-1:0]       permanent_faulty_o,
    output logic [NREP-1:0]       perf_fault_o,
    output logic                  degraded_o,
    output logic                  fail_o
);

    localparam int IDX_W = $clog2(NREP);
    localparam int TMR_W = $clog2(DECAY);
    localparam int SC_W  = (SWAP_CYC > 1) ? $clog2(SWAP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [NREP-1:0]  RESET_MASK = NREP'(3'b111);

    typedef enum logic [1:0] {
        ST_TMR,
        ST_SWAP,
        ST_DMR,
        ST_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [SC_W-1:0]   swap_cnt_q, swap_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q [NREP];
    logic [CNT_W-1:0]  cnt_d [NREP];
    logic [NREP-1:0]   faulty_q, faulty_d;
    logic [NREP-1:0]   mask_q, mask_d;
    logic [NREP-1:0]   perf_q;
    logic [NREP-1:0]   retire;
    logic [NREP-1:0]   mismatch;
    logic [NREP-1:0]   inc;
    logic              decay_tick;
    int                h_next;

    logic [IDX_W-1:0]  idx_a, idx_b, idx_c, idx_low;
    logic              any_healthy;
    logic [WIDTH-1:0]  res_a, res_b, res_c, res_low, vote;
    logic              mis_a, mis_b, mis_c, dmr_diff;

    // Lowest-indexed (up to) three healthy replicas form the active set.
    function automatic logic [NREP-1:0] pick_active(input logic [NREP-1:0] healthy);
        int taken;
        pick_active = '0;
        taken = 0;
        for (int r = 0; r < NREP; r++) begin
            if (healthy[r] && taken < 3) begin
                pick_active[r] = 1'b1;
                taken++;
            end
        end
    endfunction

    always_comb begin
        int found;
        idx_a = '0;
        idx_b = '0;
        idx_c = '0;
        found = 0;
        for (int r = 0; r < NREP; r++) begin
            if (mask_q[r]) begin
                if (found == 0) begin
                    idx_a = IDX_W'(r);
                end else if (found == 1) begin
                    idx_b = IDX_W'(r);
                end else if (found == 2) begin
                    idx_c = IDX_W'(r);
                end
                found++;
            end
        end
    end

    always_comb begin
        idx_low     = '0;
        any_healthy = 1'b0;
        for (int r = NREP - 1; r >= 0; r--) begin
            if (!faulty_q[r]) begin
                idx_low     = IDX_W'(r);
                any_healthy = 1'b1;
            end
        end
    end

    assign res_a   = res_i[int'(idx_a) * WIDTH +: WIDTH];
    assign res_b   = res_i[int'(idx_b) * WIDTH +: WIDTH];
    assign res_c   = res_i[int'(idx_c) * WIDTH +: WIDTH];
    assign res_low = res_i[int'(idx_low) * WIDTH +: WIDTH];

    assign vote     = (res_a & res_b) | (res_a & res_c) | (res_b & res_c);
    assign mis_a    = (res_a != vote);
    assign mis_b    = (res_b != vote);
    assign mis_c    = (res_c != vote);
    assign dmr_diff = (res_a != res_b);

    always_comb begin
        result_o        = '0;
        err_detected_o  = 1'b0;
        err_corrected_o = 1'b0;
        mismatch        = '0;
        case (state_q)
            ST_TMR, ST_SWAP: begin
                result_o        = vote;
                mismatch[idx_a] = mis_a;
                mismatch[idx_b] = mis_b;
                mismatch[idx_c] = mis_c;
                err_detected_o  = valid_i & (mis_a | mis_b | mis_c);
                err_corrected_o = valid_i & (mis_a ^ mis_b ^ mis_c) & ~(mis_a & mis_b & mis_c);
            end
            ST_DMR: begin
                result_o        = res_a;
                mismatch[idx_a] = dmr_diff;
                mismatch[idx_b] = dmr_diff;
                err_detected_o  = valid_i & dmr_diff;
            end
            ST_FAIL: begin
                result_o = any_healthy ? res_low : res_i[WIDTH-1:0];
            end
            default: begin
                result_o = vote;
            end
        endcase
    end

    // Counters only move for active replicas; increments win over decay.
    assign decay_tick = (timer_q == TMR_W'(DECAY - 1));
    assign timer_d    = decay_tick ? '0 : timer_q + TMR_W'(1);
    assign inc        = {NREP{valid_i && (state_q != ST_SWAP)}} & mismatch & mask_q;

    always_comb begin
        retire = '0;
        for (int r = 0; r < NREP; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc[r]) begin
                if (cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end
                retire[r] = (int'(cnt_d[r]) >= THRESH);
            end else if (decay_tick && mask_q[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    assign faulty_d = faulty_q | retire;
    assign mask_d   = pick_active(~faulty_d);
    assign h_next   = $countones(~faulty_d);

    always_comb begin
        state_d    = state_q;
        swap_cnt_d = swap_cnt_q;
        if (h_next < 2) begin
            state_d = ST_FAIL;
        end else if (|retire) begin
            if (h_next == 2) begin
                state_d = ST_DMR;
            end else begin
                state_d    = ST_SWAP;
                swap_cnt_d = '0;
            end
        end else if (state_q == ST_SWAP) begin
            if (swap_cnt_q == SC_W'(SWAP_CYC - 1)) begin
                state_d = ST_TMR;
            end else begin
                swap_cnt_d = swap_cnt_q + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TMR;
            swap_cnt_q <= '0;
            timer_q    <= '0;
            faulty_q   <= '0;
            mask_q     <= RESET_MASK;
            perf_q     <= '0;
            for (int r = 0; r < NREP; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (clear_i) begin
            state_q    <= ST_TMR;
            swap_cnt_q <= '0;
            timer_q    <= '0;
            faulty_q   <= '0;
            mask_q     <= RESET_MASK;
            perf_q     <= '0;
            for (int r = 0; r < NREP; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            swap_cnt_q <= swap_cnt_d;
            timer_q    <= timer_d;
            faulty_q   <= faulty_d;
            mask_q     <= mask_d;
            perf_q     <= retire;
            for (int r = 0; r < NREP; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign active_mask_o      = mask_q;
    assign clock_en_o         = mask_q;
    assign permanent_faulty_o = faulty_q;
    assign perf_fault_o       = perf_q;
    assign ready_o            = (state_q != ST_SWAP);
    assign degraded_o         = (state_q == ST_DMR);
    assign fail_o             = (state_q == ST_FAIL);

endmodule

// File: tb/tb_cv32e40p_ft_replica_mgr.sv
// Bench for cv32e40p_ft_replica_mgr: directed scenarios plus random traffic, checked
// against a per-replica error-count model of the redundancy manager.
module tb_cv32e40p_ft_replica_mgr;

    localparam int WIDTH    = 32;
    localparam int NREP     = 4;
    localparam int CNT_W    = 4;
    localparam int THRESH   = 8;
    localparam int DECAY    = 256;
    localparam int SWAP_CYC = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int M_TMR = 0, M_SWAP = 1, M_DMR = 2, M_FAIL = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  valid_i;
    logic [NREP*WIDTH-1:0] res_i;
    logic                  clear_i;
    logic [WIDTH-1:0]      result_o;
    logic                  ready_o, err_detected_o, err_corrected_o, degraded_o, fail_o;
    logic [NREP-1:0]       active_mask_o, clock_en_o, permanent_faulty_o, perf_fault_o;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] resv [NREP];
    int m_cnt    [NREP];
    bit m_faulty [NREP];
    bit m_perf   [NREP];
    int m_mode, m_swap_left, m_since;
    int act_idx [3];
    int act_n;

    cv32e40p_ft_replica_mgr #(
        .WIDTH(WIDTH), .NREP(NREP), .CNT_W(CNT_W), .THRESH(THRESH),
        .DECAY(DECAY), .SWAP_CYC(SWAP_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .res_i(res_i), .clear_i(clear_i),
        .result_o(result_o), .ready_o(ready_o), .err_detected_o(err_detected_o),
        .err_corrected_o(err_corrected_o), .active_mask_o(active_mask_o),
        .clock_en_o(clock_en_o), .permanent_faulty_o(permanent_faulty_o),
        .perf_fault_o(perf_fault_o), .degraded_o(degraded_o), .fail_o(fail_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int r = 0; r < NREP; r++) begin
            m_cnt[r]    = 0;
            m_faulty[r] = 1'b0;
            m_perf[r]   = 1'b0;
        end
        m_mode      = M_TMR;
        m_swap_left = 0;
        m_since     = 0;
    endfunction

    function automatic void findActive();
        act_n = 0;
        for (int r = 0; r < NREP; r++) begin
            if (!m_faulty[r] && act_n < 3) begin
                act_idx[act_n] = r;
                act_n++;
            end
        end
    endfunction

    function automatic logic [WIDTH-1:0] expectedResult();
        logic [WIDTH-1:0] out = '0;
        int ones;
        findActive();
        if (m_mode == M_TMR || m_mode == M_SWAP) begin
            for (int b = 0; b < WIDTH; b++) begin
                ones = 0;
                for (int k = 0; k < 3; k++) ones += int'(resv[act_idx[k]][b]);
                out[b] = (ones >= 2);
            end
        end else if (m_mode == M_DMR) begin
            out = resv[act_idx[0]];
        end else begin
            out = (act_n > 0) ? resv[act_idx[0]] : resv[0];
        end
        return out;
    endfunction

    task automatic compareAll(input bit v);
        logic [WIDTH-1:0] exp_res;
        logic [WIDTH-1:0] exp_mask = '0;
        logic [WIDTH-1:0] exp_pf   = '0;
        logic [WIDTH-1:0] exp_perf = '0;
        int  n_mis = 0;
        bit  voting, det, cor;
        exp_res = expectedResult();
        for (int k = 0; k < act_n; k++) exp_mask[act_idx[k]] = 1'b1;
        for (int r = 0; r < NREP; r++) begin
            exp_pf[r]   = m_faulty[r];
            exp_perf[r] = m_perf[r];
        end
        voting = (m_mode == M_TMR || m_mode == M_SWAP);
        if (voting) begin
            for (int k = 0; k < 3; k++) n_mis += (resv[act_idx[k]] != exp_res) ? 1 : 0;
        end
        det = v && ((voting && n_mis > 0) ||
                    (m_mode == M_DMR && resv[act_idx[0]] != resv[act_idx[1]]));
        cor = v && voting && (n_mis == 1);
        checkOutput("result", result_o, exp_res);
        checkOutput("err_detected", WIDTH'(err_detected_o), WIDTH'(det));
        checkOutput("err_corrected", WIDTH'(err_corrected_o), WIDTH'(cor));
        checkOutput("active_mask", WIDTH'(active_mask_o), exp_mask);
        checkOutput("clock_en", WIDTH'(clock_en_o), exp_mask);
        checkOutput("perm_faulty", WIDTH'(permanent_faulty_o), exp_pf);
        checkOutput("perf_fault", WIDTH'(perf_fault_o), exp_perf);
        checkOutput("ready", WIDTH'(ready_o), WIDTH'(m_mode != M_SWAP));
        checkOutput("degraded", WIDTH'(degraded_o), WIDTH'(m_mode == M_DMR));
        checkOutput("fail", WIDTH'(fail_o), WIDTH'(m_mode == M_FAIL));
    endtask

    task automatic modelEdge(input bit v, input bit clr);
        logic [WIDTH-1:0] exp_res;
        bit tick, mis, any_ret;
        int r, h;
        if (clr) begin
            modelReset();
            return;
        end
        m_since++;
        tick    = (m_since % DECAY == 0);
        exp_res = expectedResult();
        any_ret = 1'b0;
        for (int q = 0; q < NREP; q++) m_perf[q] = 1'b0;
        for (int k = 0; k < act_n; k++) begin
            r   = act_idx[k];
            mis = 1'b0;
            if (m_mode == M_TMR) mis = (resv[r] != exp_res);
            else if (m_mode == M_DMR) mis = (resv[act_idx[0]] != resv[act_idx[1]]);
            if (v && mis) begin
                if (m_cnt[r] < CNT_MAX) m_cnt[r]++;
                if (m_cnt[r] >= THRESH) begin
                    m_faulty[r] = 1'b1;
                    m_perf[r]   = 1'b1;
                    any_ret     = 1'b1;
                end
            end else if (tick && m_cnt[r] > 0) begin
                m_cnt[r]--;
            end
        end
        h = 0;
        for (int q = 0; q < NREP; q++) h += m_faulty[q] ? 0 : 1;
        if (any_ret) begin
            if (h < 2) m_mode = M_FAIL;
            else if (h == 2) m_mode = M_DMR;
            else begin
                m_mode      = M_SWAP;
                m_swap_left = SWAP_CYC;
            end
        end else if (m_mode == M_SWAP) begin
            m_swap_left--;
            if (m_swap_left == 0) m_mode = M_TMR;
        end
    endtask

    // One clock cycle: drive on the falling edge, check, then advance the model.
    task automatic applyStimulus(input bit v, input bit clr);
        @(negedge clk);
        valid_i = v;
        clear_i = clr;
        for (int r = 0; r < NREP; r++) res_i[r*WIDTH +: WIDTH] = resv[r];
        #1;
        compareAll(v);
        @(posedge clk);
        modelEdge(v, clr);
    endtask

    function automatic void setAll(input logic [WIDTH-1:0] val);
        for (int r = 0; r < NREP; r++) resv[r] = val;
    endfunction

    initial begin
        logic [WIDTH-1:0] base;
        int sel;
        rst_n   = 1'b1;
        valid_i = 1'b0;
        clear_i = 1'b0;
        res_i   = '0;
        setAll(32'h1234);
        modelReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mask", WIDTH'(active_mask_o), 32'h7);
        checkOutput("rst_ready", WIDTH'(ready_o), 32'h1);
        checkOutput("rst_pf", WIDTH'(permanent_faulty_o), 32'h0);
        checkOutput("rst_fail", WIDTH'(fail_o), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (2) applyStimulus(1'b1, 1'b0);

        resv[1] = 32'hFFFF;
        repeat (8) applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("r1_pf", WIDTH'(permanent_faulty_o), 32'h2);
        checkOutput("r1_perf", WIDTH'(perf_fault_o), 32'h2);
        checkOutput("r1_mask", WIDTH'(active_mask_o), 32'hD);
        checkOutput("r1_ready", WIDTH'(ready_o), 32'h0);
        setAll(32'h1234);
        repeat (3) applyStimulus(1'b1, 1'b0);

        resv[0] = 32'h1234 ^ 32'h1;
        resv[1] = 32'hFFFF;
        resv[2] = 32'h1234 ^ 32'h10;
        resv[3] = 32'h1234 ^ 32'h100;
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("maj_result", result_o, 32'h1234);
        checkOutput("maj_det", WIDTH'(err_detected_o), 32'h1);
        checkOutput("maj_cor", WIDTH'(err_corrected_o), 32'h0);

        setAll(32'h1234);
        resv[2] = 32'hDEAD;
        repeat (4) applyStimulus(1'b1, 1'b0);
        setAll(32'h1234);
        repeat (300) applyStimulus(1'b1, 1'b0);
        #1 checkOutput("decay_pf", WIDTH'(permanent_faulty_o), 32'h2);

        resv[3] = 32'hBAD0_0000;
        for (int i = 0; i < 16 && !m_faulty[3]; i++) applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("dmr_degraded", WIDTH'(degraded_o), 32'h1);
        checkOutput("dmr_mask", WIDTH'(active_mask_o), 32'h5);
        setAll(32'h1234);
        applyStimulus(1'b1, 1'b0);
        resv[0] = 32'hAAAA;
        resv[2] = 32'h5555;
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("dmr_result", result_o, 32'hAAAA);
        checkOutput("dmr_det", WIDTH'(err_detected_o), 32'h1);
        for (int i = 0; i < 20 && m_mode != M_FAIL; i++) applyStimulus(1'b1, 1'b0);
        #1 checkOutput("fail_flag", WIDTH'(fail_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < NREP; r++) resv[r] = $urandom;
            applyStimulus(1'b1, 1'b0);
        end

        setAll(32'h1234);
        applyStimulus(1'b1, 1'b1);
        #1 checkOutput("clr_mask", WIDTH'(active_mask_o), 32'h7);

        resv[1] = 32'hFFFF;
        for (int i = 0; i < 16 && !m_faulty[1]; i++) applyStimulus(1'b1, 1'b0);
        setAll(32'h1234);
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("swclr_mask", WIDTH'(active_mask_o), 32'h7);
        checkOutput("swclr_ready", WIDTH'(ready_o), 32'h1);
        checkOutput("swclr_pf", WIDTH'(permanent_faulty_o), 32'h0);

        resv[0] = 32'h0F0F;
        for (int i = 0; i < 16 && !m_faulty[0]; i++) applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("swrst_ready", WIDTH'(ready_o), 32'h1);
        checkOutput("swrst_mask", WIDTH'(active_mask_o), 32'h7);
        checkOutput("swrst_pf", WIDTH'(permanent_faulty_o), 32'h0);
        modelReset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        setAll(32'h1234);

        for (int i = 0; i < 800; i++) begin
            base = $urandom;
            setAll(base);
            sel = int'($urandom_range(0, 7));
            if (sel < 3) begin
                resv[$urandom_range(0, NREP-1)] = base ^ $urandom;
            end else if (sel == 3) begin
                resv[$urandom_range(0, NREP-1)] = $urandom;
                resv[$urandom_range(0, NREP-1)] = $urandom;
            end
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ft_replica_mgr.md
# cv32e40p_ft_replica_mgr

Parametrised N-modular redundancy manager for the fault-tolerant execution units (ALU, MULT, …). It receives the outputs of NREP identical replicas, votes the three active ones, and tracks per-replica errors in leaky counters. Replicas that cross the error threshold are retired and a clock-gated spare is swapped in under a stall handshake. When spares run out it degrades to duplex (detect-only) and then to a fail state. It sits between the replica array and the EX-stage result mux.

## Interface
Parameters:
- WIDTH, 32, bit width of each replica result
- NREP, 4, number of replicas (≥3); NREP-3 are spares
- CNT_W, 4, error counter width
- THRESH, 8, counter value at which a replica is declared permanently faulty (1..2^CNT_W-1)
- DECAY, 256, clock cycles between counter decrements (≥2)
- SWAP_CYC, 2, stall cycles when a spare is brought in (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_i  in  1  replica results valid this cycle
- res_i  in  NREP×WIDTH  replica results, index r = replica r
- clear_i  in  1  synchronous clear of all counters, fault flags and state
- result_o  out  WIDTH  voted result
- ready_o  out  1  0 = stall the stage (swap in progress)
- err_detected_o  out  1  mismatch among active replicas
- err_corrected_o  out  1  mismatch masked by the vote
- active_mask_o  out  NREP  replicas feeding the voter
- clock_en_o  out  NREP  clock-gate enables for replica input registers
- permanent_faulty_o  out  NREP  sticky retired-replica flags
- perf_fault_o  out  NREP  one-cycle pulse when replica r is retired
- degraded_o  out  1  duplex mode
- fail_o  out  1  fewer than 2 healthy replicas

## Operation
- Healthy set H = ~permanent_faulty. Active mask = the lowest-indexed min(3,|H|) members of H. It is registered and recomputed the cycle after any retirement.
- States: TMR (|H|≥3), SWAP, DMR (|H|=2), FAIL (|H|<2). Reset state is TMR.
- TMR vote: result_o = bitwise majority of the three active results, in index order a<b<c. Slot mismatch_x = (res_x ≠ result_o).
  - err_detected_o = valid_i & (any mismatch).
  - err_corrected_o = valid_i & (exactly one mismatch).
- DMR: result_o = lower-index active replica. err_detected_o = valid_i & (the two differ); both replicas count as mismatching. err_corrected_o = 0.
- FAIL: result_o = lowest healthy replica, or res_i[0] if none. fail_o = 1, detect and correct flags = 0.
- Counters, one per replica, CNT_W bits:
  - +1 on valid_i & mismatch while active and the state is not SWAP.
  - Saturate at 2^CNT_W-1.
  - A free-running DECAY timer decrements every non-zero counter that is not incrementing that cycle; an increment has priority over a decrement.
  - Counters of retired and inactive replicas are frozen.
- Retirement: when a counter's next value ≥ THRESH, the permanent_faulty bit is set at that clock edge and perf_fault pulses for one cycle. Several replicas may retire in the same cycle.
- Transitions, evaluated on the post-retirement |H|:
  - TMR → SWAP if a retirement leaves |H|≥3.
  - TMR/SWAP → DMR if |H|=2.
  - Any state → FAIL if |H|<2.
  - SWAP → TMR after SWAP_CYC cycles.
  - DMR → FAIL on a further retirement.
- SWAP: ready_o=0 and the counters do not increment. The new active mask and clock_en_o are already applied, so the spare's input registers load while the stage is stalled.
- clock_en_o = active_mask_o. Spares and retired replicas are gated off.
- clear_i has priority over every update and returns the block to its reset values.

## Timing
- Voter path (result_o, err_*_o) is combinational from res_i, valid_i and the registered active mask: 0-cycle latency.
- Counter, fault flags, state, active_mask_o, clock_en_o and perf_fault_o are registered. The mask changes 1 cycle after the mismatch that triggered retirement.
- ready_o is low from the cycle after retirement for exactly SWAP_CYC cycles.
- Reset and clear values:
  - counters 0, permanent_faulty_o 0, perf_fault_o 0
  - active_mask_o = clock_en_o = NREP'b…0111
  - ready_o 1, degraded_o 0, fail_o 0
  - state TMR, DECAY timer 0
- Reset asserted mid-SWAP aborts the swap immediately (asynchronous).
- A mismatch on an inactive replica is never counted.

## Test plan
- Reset, NREP=4, all res_i=0x1234 valid → result 0x1234, flags 0, active_mask 0111, ready 1.
- res_i[1]=0xFFFF, others 0x1234, valid 8 consecutive cycles → err_corrected 1 each cycle; on the 8th edge permanent_faulty=0010 and perf_fault pulses one cycle; next cycle active_mask=1101 and ready=0 for 2 cycles, then 1.
- res_i[0], res_i[2] differ from each other and from res_i[1] in different bits → err_detected 1, err_corrected 0, result = bitwise majority.
- 4 mismatches on replica 2, then 256+ clean cycles → counter decays to 3 (one per DECAY period); no retirement.
- Retire replicas 1 and 3 sequentially → DMR with degraded_o=1. A mismatch between 0 and 2 gives err_detected 1, result=res_i[0]. A third retirement gives fail_o=1.
- Retire replica 1, then pulse clear_i during SWAP → all flags clear next cycle, active_mask 0111, ready 1.
